// File: rtl/ffp_input_conditioner.sv
// ffp_input_conditioner
// Front-end for the fastest-finger quiz block: synchronises and debounces the
// four contestant buttons, emits a one-clock press pulse per button and
// latches which contestant pressed first in the current round.
// Build option: define SYNC_3FF_EN for a 3-flop synchroniser (default is 2).

module ffp_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_raw,
  input  logic       round_clr,
  output logic [3:0] player,
  output logic [3:0] press,
  output logic       first_valid,
  output logic [1:0] first_id
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef SYNC_3FF_EN
  localparam int SYNC_STAGES = 3;
`else
  localparam int SYNC_STAGES = 2;
`endif

  localparam logic STATE_OPEN   = 1'b0;
  localparam logic STATE_LOCKED = 1'b1;

  logic [3:0]       sync_q [SYNC_STAGES];
  logic [3:0]       sync_out;
  logic [CNT_W-1:0] cnt [4];
  logic [3:0]       flip;
  logic             state;
  logic [1:0]       lowest_idx;

  assign sync_out    = sync_q[SYNC_STAGES-1];
  assign first_valid = state;

  // Metastability chain: each raw button passes through SYNC_STAGES flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= 4'b0000;
      end
    end else begin
      sync_q[0] <= btn_raw;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  // A button flips its stable level on the edge its disagreement run completes.
  always_comb begin
    flip = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      flip[i] = (sync_out[i] != player[i]) && (cnt[i] == CNT_MAX);
    end
  end

  // Per-button debounce counters, stable levels and rising-edge press pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      player <= 4'b0000;
      press  <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      press <= flip & sync_out;
      for (int i = 0; i < 4; i++) begin
        if (sync_out[i] == player[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          cnt[i]    <= '0;
          player[i] <= sync_out[i];
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Simultaneous presses resolve to the lowest-numbered contestant.
  always_comb begin
    lowest_idx = 2'd0;
    if (press[0]) begin
      lowest_idx = 2'd0;
    end else if (press[1]) begin
      lowest_idx = 2'd1;
    end else if (press[2]) begin
      lowest_idx = 2'd2;
    end else if (press[3]) begin
      lowest_idx = 2'd3;
    end
  end

  // First-press latch: round_clr reopens the round and outranks a same-cycle press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= STATE_OPEN;
      first_id <= 2'd0;
    end else if (round_clr) begin
      state    <= STATE_OPEN;
      first_id <= 2'd0;
    end else if ((state == STATE_OPEN) && (press != 4'b0000)) begin
      state    <= STATE_LOCKED;
      first_id <= lowest_idx;
    end
  end

endmodule

// File: tb/tb_ffp_input_conditioner.sv
// tb_ffp_input_conditioner
// Directed scenarios plus randomised bouncing buttons for ffp_input_conditioner,
// checked every cycle against a history-window reference model.

module tb_ffp_input_conditioner;

  localparam int DC = 4;
`ifdef SYNC_3FF_EN
  localparam int SL = 3;
`else
  localparam int SL = 2;
`endif
  // posedges from driving a change (at a negedge) to the stable level moving
  localparam int LAT = SL + DC;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] btn_raw = 4'b0000;
  logic       round_clr = 1'b0;
  logic [3:0] player;
  logic [3:0] press;
  logic       first_valid;
  logic [1:0] first_id;

  int checks = 0;
  int failures = 0;
  bit checkEn = 1'b0;

  ffp_input_conditioner #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk),
    .rst(rst),
    .btn_raw(btn_raw),
    .round_clr(round_clr),
    .player(player),
    .press(press),
    .first_valid(first_valid),
    .first_id(first_id)
  );

  always #5 clk = ~clk;

  // Counts one comparison and reports it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drives the buttons and round clear; called at a falling edge.
  task automatic applyStimulus(input logic [3:0] btn, input logic clr);
    btn_raw   = btn;
    round_clr = clr;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: a button's stable level flips once its synchronised
  // input has disagreed with it for DC consecutive samples.
  logic [3:0] mPlayer, mPress, newPlayer, newPress;
  logic       mFv;
  logic [1:0] mId;
  logic [3:0] hist[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mPlayer = 4'b0;
      mPress  = 4'b0;
      mFv     = 1'b0;
      mId     = 2'd0;
      hist.delete();
      for (int a = 0; a < SL + DC; a++) hist.push_back(4'b0);
    end else begin
      hist.push_back(btn_raw);
      void'(hist.pop_front());
      newPlayer = mPlayer;
      newPress  = 4'b0;
      for (int i = 0; i < 4; i++) begin
        bit allDiff;
        allDiff = 1'b1;
        for (int age = SL; age < SL + DC; age++) begin
          if (hist[hist.size() - 1 - age][i] == mPlayer[i]) allDiff = 1'b0;
        end
        if (allDiff) begin
          newPlayer[i] = ~mPlayer[i];
          newPress[i]  = newPlayer[i];
        end
      end
      if (round_clr) begin
        mFv = 1'b0;
        mId = 2'd0;
      end else if (!mFv && mPress != 4'b0) begin
        mFv = 1'b1;
        for (int i = 3; i >= 0; i--) if (mPress[i]) mId = 2'(i);
      end
      mPlayer = newPlayer;
      mPress  = newPress;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checkEn && !rst) begin
      checkOutput("model_player", 32'(player), 32'(mPlayer));
      checkOutput("model_press", 32'(press), 32'(mPress));
      checkOutput("model_first_valid", 32'(first_valid), 32'(mFv));
      checkOutput("model_first_id", 32'(first_id), 32'(mId));
    end
  end

  task automatic releaseAndClear();
    applyStimulus(4'b0000, 1'b0);
    tick(LAT + 3);
    applyStimulus(4'b0000, 1'b1);
    tick(1);
    applyStimulus(4'b0000, 1'b0);
    tick(1);
  endtask

  int holdCnt[4];
  logic [3:0] rb;

  initial begin
    #1 rst = 1'b1;
    tick(3);
    rst = 1'b0;
    checkEn = 1'b1;
    checkOutput("reset_player", 32'(player), 32'h0);
    checkOutput("reset_press", 32'(press), 32'h0);
    checkOutput("reset_first_valid", 32'(first_valid), 32'h0);
    checkOutput("reset_first_id", 32'(first_id), 32'h0);

    // clean press of player 1
    applyStimulus(4'b0001, 1'b0);
    tick(LAT - 1);
    checkOutput("clean_player_early", 32'(player), 32'h0);
    tick(1);
    checkOutput("clean_player", 32'(player), 32'h1);
    checkOutput("clean_press", 32'(press), 32'h1);
    tick(1);
    checkOutput("clean_press_once", 32'(press), 32'h0);
    checkOutput("clean_first_valid", 32'(first_valid), 32'h1);
    checkOutput("clean_first_id", 32'(first_id), 32'h0);
    tick(6);
    checkOutput("clean_held", 32'(player), 32'h1);
    releaseAndClear();

    // bounce on button 2 then held
    for (int b = 0; b < 4; b++) begin
      applyStimulus((b % 2 == 0) ? 4'b0100 : 4'b0000, 1'b0);
      tick(1);
      checkOutput("bounce_no_press", 32'(press), 32'h0);
    end
    applyStimulus(4'b0100, 1'b0);
    for (int t = 1; t < LAT; t++) begin
      tick(1);
      checkOutput("bounce_quiet", 32'(press), 32'h0);
    end
    tick(1);
    checkOutput("bounce_rise", 32'(player), 32'h4);
    checkOutput("bounce_press", 32'(press), 32'h4);
    releaseAndClear();

    // race: player 4 then player 2 two clocks later
    applyStimulus(4'b1000, 1'b0);
    tick(2);
    applyStimulus(4'b1010, 1'b0);
    tick(LAT - 2);
    checkOutput("race_press3", 32'(press), 32'h8);
    tick(1);
    checkOutput("race_first_valid", 32'(first_valid), 32'h1);
    checkOutput("race_first_id", 32'(first_id), 32'h3);
    tick(1);
    checkOutput("race_press1", 32'(press), 32'h2);
    tick(1);
    checkOutput("race_id_kept", 32'(first_id), 32'h3);
    releaseAndClear();

    // tie between players 2 and 3
    applyStimulus(4'b0110, 1'b0);
    tick(LAT);
    checkOutput("tie_press", 32'(press), 32'h6);
    tick(1);
    checkOutput("tie_first_id", 32'(first_id), 32'h1);
    checkOutput("tie_first_valid", 32'(first_valid), 32'h1);

    // round clear with everyone held
    applyStimulus(4'b1111, 1'b0);
    tick(LAT + 2);
    applyStimulus(4'b1111, 1'b1);
    tick(1);
    applyStimulus(4'b1111, 1'b0);
    checkOutput("clr_open", 32'(first_valid), 32'h0);
    for (int t = 0; t < 5; t++) begin
      tick(1);
      checkOutput("clr_no_relatch", 32'(first_valid), 32'h0);
    end
    applyStimulus(4'b1011, 1'b0);
    tick(LAT + 1);
    applyStimulus(4'b1111, 1'b0);
    tick(LAT + 1);
    checkOutput("clr_new_valid", 32'(first_valid), 32'h1);
    checkOutput("clr_new_id", 32'(first_id), 32'h2);

    // async reset mid-count with player 4 held
    applyStimulus(4'b1000, 1'b0);
    tick(2);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_player", 32'(player), 32'h0);
    checkOutput("arst_press", 32'(press), 32'h0);
    checkOutput("arst_first_valid", 32'(first_valid), 32'h0);
    checkOutput("arst_first_id", 32'(first_id), 32'h0);
    tick(2);
    rst = 1'b0;
    tick(LAT - 1);
    checkOutput("arst_no_early", 32'(press), 32'h0);
    tick(1);
    checkOutput("arst_press3", 32'(press), 32'h8);
    tick(1);
    checkOutput("arst_first_id3", 32'(first_id), 32'h3);
    releaseAndClear();

    // random bouncing buttons and round clears against the model
    rb = 4'b0000;
    for (int i = 0; i < 4; i++) holdCnt[i] = $urandom_range(1, 2 * DC + 2);
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (holdCnt[i] == 0) begin
          rb[i] = ~rb[i];
          holdCnt[i] = $urandom_range(1, 2 * DC + 2);
        end else begin
          holdCnt[i]--;
        end
      end
      applyStimulus(rb, ($urandom_range(0, 11) == 0) ? 1'b1 : 1'b0);
      if (cyc == 300) begin
        #2 rst = 1'b1;
        tick(1);
        rst = 1'b0;
      end else begin
        tick(1);
      end
    end
    applyStimulus(4'b0000, 1'b0);
    tick(LAT + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
